nfc_ecc_fix: RTL and testbench

Applies BCH decoder error locations to the NAND page buffer in the `clk` domain. It sits directly downstream of the ECC correction bridge. On the `ecc_dec_rdy` pulse it pops error bit-locations from the bridge FIFO through `mem_if_rd` / `mem_dec_addr`. For each location it performs a read-modify-write on the 16-bit sector buffer to flip the erroneous bit, then reports a completion pulse and status.

---
 rtl/nfc_ecc_fix.sv | 204 ++++++++++++++++++++
 tb/tb_nfc_ecc_fix.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_ecc_fix.sv
// Applies BCH error locations to the 16-bit sector buffer by read-modify-write bit flips.
// Optional define NFC_ECC_FIX_BOUND_EN: skip locations that fall past the sector data words.
module nfc_ecc_fix #(
   parameter int ECC_AWID   = 13,
   parameter int BUF_AWID   = 9,
   parameter int SEC_BASE_W = 9,
   parameter int SEC_WORDS  = 256,
   parameter int ERR_MAX    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ecc_dec_rdy,
   input  logic [2:0]            ecc_err_num,
   input  logic                  ecc_uncor,
   input  logic [SEC_BASE_W-1:0] sec_base,
   input  logic                  cor_clr,
   output logic                  mem_if_rd,
   input  logic [ECC_AWID-1:0]   mem_dec_addr,
   output logic                  buf_rd,
   output logic                  buf_wr,
   output logic [BUF_AWID-1:0]   buf_addr,
   output logic [15:0]           buf_wdat,
   input  logic [15:0]           buf_rdat,
   output logic                  cor_busy,
   output logic                  cor_done,
   output logic                  cor_fail,
   output logic [2:0]            cor_fixed,
   output logic [2:0]            cor_skip,
   output logic                  cor_ovr
);

   localparam int WOFS_W = ECC_AWID - 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_RD,
      S_WAIT,
      S_WR,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          rem_q, rem_d;
   logic [2:0]          fixed_q, fixed_d;
   logic                fail_q, fail_d;
   logic                ovr_q, ovr_d;
   logic [SEC_BASE_W-1:0] base_q, base_d;
   logic [WOFS_W-1:0]   wofs_q, wofs_d;
   logic [3:0]          bit_q, bit_d;
   logic [15:0]         rdat_q, rdat_d;
   logic                bad_sec;
   logic                in_range;

   function automatic logic [15:0] flip_mask(input logic [3:0] b);
      return 16'h0001 << b;
   endfunction

   // Buffer address wraps modulo the buffer size.
   function automatic logic [BUF_AWID-1:0] word_addr(input logic [SEC_BASE_W-1:0] b,
                                                     input logic [WOFS_W-1:0] o);
      logic [31:0] s;
      s = 32'(b) + 32'(o);
      return s[BUF_AWID-1:0];
   endfunction

   assign bad_sec = ecc_uncor || (32'(ecc_err_num) > 32'(ERR_MAX));

`ifdef NFC_ECC_FIX_BOUND_EN
   logic [2:0] skip_q, skip_d;
   assign in_range = 32'(mem_dec_addr[ECC_AWID-1:4]) < 32'(SEC_WORDS);
   assign cor_skip = skip_q;
`else
   assign in_range = 1'b1;
   assign cor_skip = 3'd0;
`endif

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      fixed_d   = fixed_q;
      fail_d    = fail_q;
      ovr_d     = ovr_q;
      base_d    = base_q;
      wofs_d    = wofs_q;
      bit_d     = bit_q;
      rdat_d    = rdat_q;
`ifdef NFC_ECC_FIX_BOUND_EN
      skip_d    = skip_q;
`endif
      mem_if_rd = 1'b0;
      buf_rd    = 1'b0;
      buf_wr    = 1'b0;
      buf_addr  = '0;
      buf_wdat  = '0;
      cor_done  = 1'b0;

      if (cor_clr) begin
         // Abort drops any in-flight access; status keeps partial values.
         state_d = S_IDLE;
      end else begin
         if (ecc_dec_rdy && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (ecc_dec_rdy) begin
                  fixed_d = 3'd0;
                  fail_d  = 1'b0;
                  ovr_d   = 1'b0;
`ifdef NFC_ECC_FIX_BOUND_EN
                  skip_d  = 3'd0;
`endif
                  base_d  = sec_base;
                  rem_d   = ecc_err_num;
                  if (bad_sec) begin
                     fail_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (ecc_err_num == 3'd0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               mem_if_rd = 1'b1;
               wofs_d    = mem_dec_addr[ECC_AWID-1:4];
               bit_d     = mem_dec_addr[3:0];
               rem_d     = rem_q - 3'd1;
               if (!in_range) begin
`ifdef NFC_ECC_FIX_BOUND_EN
                  skip_d = skip_q + 3'd1;
`endif
                  state_d = (rem_q != 3'd1) ? S_FETCH : S_DONE;
               end else begin
                  state_d = S_RD;
               end
            end
            S_RD: begin
               buf_rd   = 1'b1;
               buf_addr = word_addr(base_q, wofs_q);
               state_d  = S_WAIT;
            end
            S_WAIT: begin
               rdat_d  = buf_rdat;
               state_d = S_WR;
            end
            S_WR: begin
               buf_wr   = 1'b1;
               buf_addr = word_addr(base_q, wofs_q);
               buf_wdat = rdat_q ^ flip_mask(bit_q);
               fixed_d  = fixed_q + 3'd1;
               state_d  = (rem_q != 3'd0) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
               cor_done = 1'b1;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= 3'd0;
         fixed_q <= 3'd0;
         fail_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         fixed_q <= fixed_d;
         fail_q  <= fail_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef NFC_ECC_FIX_BOUND_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_q <= 3'd0;
      end else begin
         skip_q <= skip_d;
      end
   end
`endif

   // Datapath holding registers carry no reset; they are qualified by state.
   always_ff @(posedge clk) begin
      base_q <= base_d;
      wofs_q <= wofs_d;
      bit_q  <= bit_d;
      rdat_q <= rdat_d;
   end

   assign cor_busy  = (state_q != S_IDLE);
   assign cor_fail  = fail_q;
   assign cor_fixed = fixed_q;
   assign cor_ovr   = ovr_q;

endmodule

// File: tb/tb_nfc_ecc_fix.sv
// Randomized bench for nfc_ecc_fix with a transaction-level expectation model.
module tb_nfc_ecc_fix;
   localparam int ECC_AWID = 13, BUF_AWID = 9, SEC_BASE_W = 9, SEC_WORDS = 256, ERR_MAX = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  ecc_dec_rdy = 1'b0;
   logic [2:0]            ecc_err_num = '0;
   logic                  ecc_uncor = 1'b0;
   logic [SEC_BASE_W-1:0] sec_base = '0;
   logic                  cor_clr = 1'b0;
   logic                  mem_if_rd;
   logic [ECC_AWID-1:0]   mem_dec_addr = '0;
   logic                  buf_rd, buf_wr;
   logic [BUF_AWID-1:0]   buf_addr;
   logic [15:0]           buf_wdat;
   logic [15:0]           buf_rdat = '0;
   logic                  cor_busy, cor_done, cor_fail, cor_ovr;
   logic [2:0]            cor_fixed, cor_skip;

   nfc_ecc_fix #(.ECC_AWID(ECC_AWID), .BUF_AWID(BUF_AWID), .SEC_BASE_W(SEC_BASE_W),
                 .SEC_WORDS(SEC_WORDS), .ERR_MAX(ERR_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .ecc_dec_rdy(ecc_dec_rdy), .ecc_err_num(ecc_err_num),
      .ecc_uncor(ecc_uncor), .sec_base(sec_base), .cor_clr(cor_clr), .mem_if_rd(mem_if_rd),
      .mem_dec_addr(mem_dec_addr), .buf_rd(buf_rd), .buf_wr(buf_wr), .buf_addr(buf_addr),
      .buf_wdat(buf_wdat), .buf_rdat(buf_rdat), .cor_busy(cor_busy), .cor_done(cor_done),
      .cor_fail(cor_fail), .cor_fixed(cor_fixed), .cor_skip(cor_skip), .cor_ovr(cor_ovr));

   always #5 clk = ~clk;

   typedef struct {
      bit busy; bit done; bit pop; bit rd; bit wr; bit chk; bit fail;
      int addr; int wdat; int fixed; int skip;
   } rec_t;

   rec_t              exq[$];
   rec_t              cr;
   logic [ECC_AWID-1:0] fifo[$];
   int                cur_locs[$];
   logic [15:0]       bmem [0:511];
   logic [15:0]       rmem [0:511];
   logic [15:0]       scr  [0:511];
   int checks = 0, errors = 0;
   bit mdl_en = 0;
   int last_fixed = 0, last_skip = 0;
   bit last_fail = 0, exp_ovr = 0;
   int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, pop_cnt = 0, rd_cnt = 0, wr_cnt = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic rec_t blank(input bit busy, input int f, input int s);
      rec_t r;
      r.busy = busy; r.done = 0; r.pop = 0; r.rd = 0; r.wr = 0; r.chk = 1; r.fail = 0;
      r.addr = 0; r.wdat = 0; r.fixed = f; r.skip = s;
      return r;
   endfunction

   // Buffer and error FIFO models.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (buf_wr) bmem[buf_addr] <= buf_wdat;
      if (buf_rd) buf_rdat <= bmem[buf_addr];
      if (mem_if_rd && fifo.size() > 0) void'(fifo.pop_front());
      mem_dec_addr <= (fifo.size() > 0) ? fifo[0] : '0;
   end

   // Per-cycle comparison against the expectation queue.
   always @(negedge clk) begin
      if (mdl_en) begin
         if (cor_done) begin done_cnt++; done_cyc = cyc; end
         pop_cnt += int'(mem_if_rd);
         rd_cnt  += int'(buf_rd);
         wr_cnt  += int'(buf_wr);
         chk("rd_wr_excl", int'(buf_rd & buf_wr) + int'(mem_if_rd & (buf_rd | buf_wr)), 0);
         if (exq.size() > 0) begin
            cr = exq.pop_front();
            chk("busy", cor_busy, cr.busy);
            chk("done", cor_done, cr.done);
            chk("pop", mem_if_rd, cr.pop);
            chk("buf_rd", buf_rd, cr.rd);
            chk("buf_wr", buf_wr, cr.wr);
            if (cr.rd || cr.wr) chk("buf_addr", buf_addr, cr.addr);
            if (cr.wr) begin
               chk("buf_wdat", buf_wdat, cr.wdat);
               rmem[cr.addr] = cr.wdat[15:0];
            end
            if (cr.chk) begin
               chk("fixed", cor_fixed, cr.fixed);
               chk("skip", cor_skip, cr.skip);
               chk("fail", cor_fail, cr.fail);
            end
            if (cr.done) begin
               last_fixed = cr.fixed; last_skip = cr.skip; last_fail = cr.fail;
            end
         end else begin
            chk("idle_busy", cor_busy, 0);
            chk("idle_done", cor_done, 0);
            chk("idle_strobes", int'(mem_if_rd) + int'(buf_rd) + int'(buf_wr), 0);
            chk("idle_fixed", cor_fixed, last_fixed);
            chk("idle_skip", cor_skip, last_skip);
            chk("idle_fail", cor_fail, last_fail);
            chk("idle_ovr", cor_ovr, exp_ovr);
         end
      end
   end

   task automatic start_sector(input int n, input bit unc, input int base);
      rec_t r;
      int f, s, loc, wofs, bt, addr;
      bit skp;
      logic [15:0] m;
      @(posedge clk); #1;
      scr = rmem;
      ecc_dec_rdy = 1'b1;
      ecc_err_num = n[2:0];
      ecc_uncor   = unc;
      sec_base    = base[SEC_BASE_W-1:0];
      start_cyc   = cyc;
      exp_ovr     = 0;
      r = blank(0, 0, 0); r.chk = 0;
      exq.push_back(r);
      f = 0; s = 0;
      if (unc || n > ERR_MAX) begin
         r = blank(1, 0, 0); r.done = 1; r.fail = 1;
         exq.push_back(r);
      end else begin
         for (int i = 0; i < n; i++) begin
            loc  = cur_locs[i];
            fifo.push_back(loc[ECC_AWID-1:0]);
            wofs = loc >> 4;
            bt   = loc & 15;
            addr = (base + wofs) % 512;
            skp  = 0;
`ifdef NFC_ECC_FIX_BOUND_EN
            skp  = (wofs >= SEC_WORDS);
`endif
            r = blank(1, f, s); r.pop = 1; exq.push_back(r);
            if (skp) begin
               s++;
            end else begin
               r = blank(1, f, s); r.rd = 1; r.addr = addr; exq.push_back(r);
               r = blank(1, f, s); exq.push_back(r);
               m = 16'h0001 << bt;
               r = blank(1, f, s); r.wr = 1; r.addr = addr; r.wdat = int'(scr[addr] ^ m);
               scr[addr] = scr[addr] ^ m;
               exq.push_back(r);
               f++;
            end
         end
         r = blank(1, f, s); r.done = 1; exq.push_back(r);
      end
      @(posedge clk); #1;
      ecc_dec_rdy = 1'b0;
      ecc_uncor   = 1'($urandom);
      ecc_err_num = 3'($urandom);
      sec_base    = SEC_BASE_W'($urandom);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && exq.size() > 0; k++) @(posedge clk);
      #1;
      if (exq.size() > 0) begin
         chk("timeout", exq.size(), 0);
         exq.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic set_word(input int a, input logic [15:0] v);
      bmem[a] = v; rmem[a] = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, r0, w0, d0, n, wofs, loc, mism;
      bit unc;
      for (int i = 0; i < 512; i++) set_word(i, 16'($urandom));
      #12;
      chk("rst_busy", cor_busy, 0);
      chk("rst_outs", int'(cor_done) + int'(cor_fail) + int'(cor_ovr) + int'(mem_if_rd) +
          int'(buf_rd) + int'(buf_wr) + int'(cor_fixed) + int'(cor_skip), 0);
      chk("rst_addr", int'(buf_addr) + int'(buf_wdat), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mdl_en = 1;
      @(posedge clk); #1;

      // Two errors in separate words
      set_word(1, 16'h0000); set_word(255, 16'h0000);
      cur_locs = '{'h0013, 'h0FF0};
      start_sector(2, 0, 0);
      wait_idle();
      chk("t1_word1", bmem[1], 16'h0008);
      chk("t1_wordFF", bmem[255], 16'h0001);
      chk("t1_fixed", cor_fixed, 2);
      chk("t1_latency", done_cyc - start_cyc, 9);

      // Uncorrectable sector
      p0 = pop_cnt; r0 = rd_cnt; w0 = wr_cnt;
      cur_locs = '{'h0010, 'h0020, 'h0030};
      start_sector(3, 1, 5);
      wait_idle();
      chk("t2_pops", pop_cnt - p0, 0);
      chk("t2_bufacc", (rd_cnt - r0) + (wr_cnt - w0), 0);
      chk("t2_fail", cor_fail, 1);
      chk("t2_latency", done_cyc - start_cyc, 1);

      // Location in the parity region
      set_word(256, 16'h0000);
      p0 = pop_cnt; r0 = rd_cnt;
      cur_locs = '{'h1005};
      start_sector(1, 0, 0);
      wait_idle();
      chk("t3_pops", pop_cnt - p0, 1);
`ifdef NFC_ECC_FIX_BOUND_EN
      chk("t3_skip", cor_skip, 1);
      chk("t3_fixed", cor_fixed, 0);
      chk("t3_rd", rd_cnt - r0, 0);
      chk("t3_word", bmem[256], 16'h0000);
`else
      chk("t3_fixed", cor_fixed, 1);
      chk("t3_word", bmem[256], 16'h0020);
`endif

      // Duplicate location restores the word
      set_word(2, 16'hA5A5);
      cur_locs = '{'h0021, 'h0021};
      start_sector(2, 0, 0);
      wait_idle();
      chk("t4_word", bmem[2], 16'hA5A5);
      chk("t4_fixed", cor_fixed, 2);

      // Abort during the second read
      d0 = done_cnt; w0 = wr_cnt;
      cur_locs = '{'h0030, 'h0045, 'h005A, 'h006F};
      start_sector(4, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      cor_clr = 1'b1;
      cr = exq[0];
      cr.rd = 0; cr.fixed = 1;
      exq.delete();
      exq.push_back(cr);
      last_fixed = 1; last_skip = 0; last_fail = 0;
      @(posedge clk); #1;
      cor_clr = 1'b0;
      fifo.delete();
      chk("t5_idle", cor_busy, 0);
      chk("t5_fixed", cor_fixed, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_writes", wr_cnt - w0, 1);

      // Start pulse while busy
      cur_locs = '{'h0101, 'h0202, 'h0303};
      start_sector(3, 0, 17);
      @(posedge clk); #1;
      ecc_dec_rdy = 1'b1; ecc_err_num = 3'd1; exp_ovr = 1;
      @(posedge clk); #1;
      ecc_dec_rdy = 1'b0;
      chk("t6_ovr_set", cor_ovr, 1);
      wait_idle();
      chk("t6_fixed", cor_fixed, 3);
      chk("t6_ovr_hold", cor_ovr, 1);

      // Asynchronous reset mid-WAIT
      cur_locs = '{'h0044, 'h0055};
      start_sector(2, 0, 3);
      @(posedge clk); #1;
      ecc_dec_rdy = 1'b1; exp_ovr = 1;
      @(posedge clk); #1;
      ecc_dec_rdy = 1'b0;
      chk("t6_busy_pre", cor_busy, 1);
      chk("t6_ovr_pre", cor_ovr, 1);
      #2;
      mdl_en = 0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", cor_busy, 0);
      chk("t6_rst_ovr", cor_ovr, 0);
      chk("t6_rst_outs", int'(cor_done) + int'(cor_fail) + int'(mem_if_rd) + int'(buf_rd) +
          int'(buf_wr) + int'(cor_fixed) + int'(cor_skip) + int'(buf_addr) + int'(buf_wdat), 0);
      exq.delete(); fifo.delete();
      last_fixed = 0; last_skip = 0; last_fail = 0; exp_ovr = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mdl_en = 1;

      // Randomized sectors
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(0, 15);
         if (n < 2) n = 0;
         else if (n < 3) n = $urandom_range(5, 7);
         else n = $urandom_range(1, 4);
         unc = ($urandom_range(0, 9) == 0);
         cur_locs.delete();
         for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 4) == 0) begin
               loc = cur_locs[i-1];
            end else begin
               wofs = $urandom_range(0, 300);
               loc  = wofs * 16 + $urandom_range(0, 15);
            end
            cur_locs.push_back(loc);
         end
         start_sector(n, unc, $urandom_range(0, 511));
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      #1;
      mism = 0;
      for (int i = 0; i < 512; i++) if (bmem[i] !== rmem[i]) mism++;
      chk("buffer_image", mism, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
